// File: rtl/led_pwm_pkg.sv
// Shared definitions for the multi-channel breathing-LED PWM controller:
// mode encoding, config-port FSM states and the triangle fold helper.
package led_pwm_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF     = 2'd0;
  localparam mode_t MODE_ON      = 2'd1;
  localparam mode_t MODE_BREATHE = 2'd2;
  localparam mode_t MODE_BLINK   = 2'd3;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_t;

  // Folds a (bits+1)-wide phase into a bits-wide triangle: the upper half of
  // the phase range counts back down, which is just the bitwise complement.
  function automatic logic [15:0] tri_level(input logic [16:0] phase,
                                            input logic [4:0]  bits);
    logic [16:0] mask;
    logic        msb;
    mask = (17'd1 << bits) - 17'd1;
    msb  = |(phase & (17'd1 << bits));
    return 16'((msb ? ~phase : phase) & mask);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: mode/offset registers, registered triangle level and the
// output decision. LED_PWM_GAMMA_EN adds a square-law level and one stage.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int COUNTER_BITS = 13,
  parameter int CHANNELS     = 3,
  parameter int IDX          = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COUNTER_BITS-1:0] counter,
  input  logic [COUNTER_BITS:0]   master,
  input  logic                    apply_en,
  input  mode_t                   cfg_mode,
  input  logic [COUNTER_BITS:0]   cfg_phase,
  output logic                    led
);

  localparam int PW      = COUNTER_BITS + 1;
  localparam int OFF_RST = (IDX * (1 << PW)) / CHANNELS;
  localparam logic [PW-1:0] OFFSET_RST = PW'(OFF_RST);

  mode_t                   mode;
  logic [PW-1:0]           offset;
  logic [PW-1:0]           phase;
  logic [COUNTER_BITS-1:0] tri_now;
  logic [COUNTER_BITS-1:0] level_r;
  logic [COUNTER_BITS-1:0] level_eff;
  logic                    led_next;

  assign phase   = master + offset;
  assign tri_now = COUNTER_BITS'(tri_level(17'(phase), 5'(COUNTER_BITS)));

`ifdef LED_PWM_GAMMA_EN
  logic [2*COUNTER_BITS-1:0] level_sq;
  logic                      led_raw;

  always_comb begin
    level_sq  = {{COUNTER_BITS{1'b0}}, level_r} * {{COUNTER_BITS{1'b0}}, level_r};
    level_eff = COUNTER_BITS'(level_sq >> COUNTER_BITS);
  end
`else
  assign level_eff = level_r;
`endif

  always_comb begin
    led_next = 1'b0;
    case (mode)
      MODE_OFF:     led_next = 1'b0;
      MODE_ON:      led_next = 1'b1;
      MODE_BREATHE: led_next = (counter < level_eff);
      MODE_BLINK:   led_next = phase[PW-1];
      default:      led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= MODE_BREATHE;
      offset  <= OFFSET_RST;
      level_r <= '0;
      led     <= 1'b0;
`ifdef LED_PWM_GAMMA_EN
      led_raw <= 1'b0;
`endif
    end else begin
      if (apply_en) begin
        mode   <= cfg_mode;
        offset <= cfg_phase;
      end
      level_r <= tri_now;
`ifdef LED_PWM_GAMMA_EN
      // Extra stage keeps every mode aligned with the slower gamma path.
      led_raw <= led_next;
      led     <= led_raw;
`else
      led     <= led_next;
`endif
    end
  end

endmodule

// File: rtl/led_pwm_multi.sv
// Multi-channel breathing-LED PWM top: shared counter/master phase, frame tick
// and a valid/ready config port applied at frame ends. Option: LED_PWM_GAMMA_EN.
//
// state    | meaning
// CFG_IDLE | cfg_ready=1, no write pending
// CFG_PEND | write captured, waiting for counter all-ones to apply it
module led_pwm_multi
  import led_pwm_pkg::*;
#(
  parameter  int CHANNELS     = 3,
  parameter  int COUNTER_BITS = 13,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_chan,
  input  logic [1:0]              cfg_mode,
  input  logic [COUNTER_BITS:0]   cfg_phase,
  output logic [CHANNELS-1:0]     leds,
  output logic                    frame_tick
);

  localparam logic [COUNTER_BITS-1:0] CNT_ONE = 1;
  localparam logic [COUNTER_BITS:0]   MST_ONE = 1;

  logic [COUNTER_BITS-1:0] counter;
  logic [COUNTER_BITS:0]   master;
  logic                    cnt_max;

  cfg_state_t              state, state_next;
  logic                    apply;
  logic [CH_W-1:0]         pend_chan;
  mode_t                   pend_mode;
  logic [COUNTER_BITS:0]   pend_phase;

  assign cnt_max = &counter;

  always_ff @(posedge clk) begin
    if (reset) begin
      counter    <= '0;
      master     <= '0;
      frame_tick <= 1'b0;
    end else begin
      counter    <= counter + CNT_ONE;
      frame_tick <= (counter == '0);
      if (cnt_max) begin
        master <= master + MST_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CFG_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CFG_IDLE: if (cfg_valid) state_next = CFG_PEND;
      CFG_PEND: if (cnt_max)   state_next = CFG_IDLE;
      default:  state_next = CFG_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == CFG_IDLE);
    apply     = (state == CFG_PEND) && cnt_max;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_chan  <= '0;
      pend_mode  <= MODE_OFF;
      pend_phase <= '0;
    end else if (cfg_valid && cfg_ready) begin
      pend_chan  <= cfg_chan;
      pend_mode  <= cfg_mode;
      pend_phase <= cfg_phase;
    end
  end

  // Out-of-range channel numbers match no instance, so their apply is a no-op.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_pwm_channel #(
      .COUNTER_BITS (COUNTER_BITS),
      .CHANNELS     (CHANNELS),
      .IDX          (i)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .counter   (counter),
      .master    (master),
      .apply_en  (apply && (pend_chan == CH_W'(i))),
      .cfg_mode  (pend_mode),
      .cfg_phase (pend_phase),
      .led       (leds[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_multi.sv
// Scoreboard bench for led_pwm_multi (CHANNELS=3, COUNTER_BITS=4) against an
// arithmetic reference model of the frame/phase/handshake rules.
module tb_led_pwm_multi;

  localparam int CH = 3;
  localparam int CB = 4;
  localparam int FR = 16;
  localparam int PH = 32;
`ifdef LED_PWM_GAMMA_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_chan = '0;
  logic [1:0] cfg_mode = '0;
  logic [4:0] cfg_phase = '0;
  logic [2:0] leds;
  logic       frame_tick;

  always #5 clk = ~clk;

  led_pwm_multi #(.CHANNELS(CH), .COUNTER_BITS(CB)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_mode   (cfg_mode),
    .cfg_phase  (cfg_phase),
    .leds       (leds),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [2:0] leds;
    logic       ft;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // reference model state
  int   k = 0;
  int   mode_m[CH];
  int   off_m[CH];
  int   lvl_m[CH];
  bit   dly_m[CH];
  bit   rdy_m = 1'b1;
  bit   pend_m = 1'b0;
  int   pc = 0, pm = 0, pp = 0;
  bit   duty_en = 1'b1;
  int   hi_cnt[PH];

  function automatic int tri_ref(input int p);
    int q;
    q = p % PH;
    return (q >= FR) ? (PH - 1 - q) : q;
  endfunction

  function automatic int eff_ref(input int l);
    return (G != 0) ? (l * l) / FR : l;
  endfunction

  function automatic int off_rst(input int i);
    return (i * PH) / CH;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act == exp_v) passes++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t k=%0d", name, act, exp_v, $time, k);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out at t=%0t", name, $time);
  endtask

  always @(posedge clk) begin : model
    exp_t e;
    int   cnt_o, mst_o, p;
    bit   dec, acc, app;
    e = '0;
    if (reset) begin
      k = 0;
      for (int i = 0; i < CH; i++) begin
        mode_m[i] = 2;
        off_m[i]  = off_rst(i);
        lvl_m[i]  = 0;
        dly_m[i]  = 1'b0;
      end
      pend_m = 1'b0;
      rdy_m  = 1'b1;
      e.rdy  = 1'b1;
    end else begin
      cnt_o = k % FR;
      mst_o = (k / FR) % PH;
      for (int i = 0; i < CH; i++) begin
        p = (mst_o + off_m[i]) % PH;
        case (mode_m[i])
          0: dec = 1'b0;
          1: dec = 1'b1;
          2: dec = (cnt_o < eff_ref(lvl_m[i]));
          default: dec = (p >= FR);
        endcase
        if (G != 0) begin
          e.leds[i] = dly_m[i];
          dly_m[i]  = dec;
        end else begin
          e.leds[i] = dec;
        end
        lvl_m[i] = tri_ref(p);
      end
      e.ft = (cnt_o == 0);
      acc = cfg_valid && rdy_m;
      app = pend_m && (cnt_o == FR - 1);
      if (app) begin
        if (pc < CH) begin
          mode_m[pc] = pm;
          off_m[pc]  = pp;
        end
        pend_m = 1'b0;
        rdy_m  = 1'b1;
      end
      if (acc) begin
        pend_m = 1'b1;
        pc = int'(cfg_chan);
        pm = int'(cfg_mode);
        pp = int'(cfg_phase);
        rdy_m = 1'b0;
      end
      e.rdy = rdy_m;
      k++;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    int   w;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("leds", int'(leds), int'(e.leds));
      chk("frame_tick", int'(frame_tick), int'(e.ft));
      chk("cfg_ready", int'(cfg_ready), int'(e.rdy));
      if (duty_en) begin
        w = k - 2 - G;
        if (w >= 0 && w < PH * FR) hi_cnt[w / FR] += int'(leds[0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((k % FR) != c && n < 100);
    if ((k % FR) != c) timeout("wait_cnt");
  endtask

  // Entered and left just after a rising edge; holds valid until accepted.
  task automatic cfg_write(input int ch, input int md, input int ph);
    int n;
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_mode  = 2'(md);
    cfg_phase = 5'(ph);
    n = 0;
    forever begin
      @(negedge clk);
      if (cfg_ready) begin
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        return;
      end
      n++;
      if (n > 100) begin
        timeout("cfg_write");
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        return;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, gap;
    for (int i = 0; i < PH; i++) hi_cnt[i] = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // channel 1 to ON, presented at counter 7
    wait_cnt(6);
    step(1);
    cfg_write(1, 1, off_rst(1));

    // out-of-range channel, then a second write stalled behind it
    wait_cnt(3);
    step(1);
    cfg_write(3, 0, 0);
    cfg_write(2, 3, 5);

    // free-run past master 20 to collect led0 duty windows
    n = 0;
    while (k < FR * 21 + 8 && n < 600) begin
      step(1);
      n++;
    end
    if (k < FR * 21 + 8) timeout("free_run");
    duty_en = 1'b0;
    chk("duty_m0",  hi_cnt[0],  eff_ref(tri_ref(0)));
    chk("duty_m5",  hi_cnt[5],  eff_ref(tri_ref(5)));
    chk("duty_m8",  hi_cnt[8],  eff_ref(tri_ref(8)));
    chk("duty_m20", hi_cnt[20], eff_ref(tri_ref(20)));

    // pending write discarded by a mid-frame reset
    wait_cnt(2);
    step(1);
    cfg_write(0, 0, 0);
    step(4);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(3 * FR);

    // randomized config traffic with occasional boundary writes and resets
    for (int it = 0; it < 40; it++) begin
      gap = $urandom_range(0, 12);
      step(gap);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        wait_cnt(14);
        step(1);
      end
      cfg_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, PH - 1));
    end
    step(2 * FR);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
